// File: rtl/matmul_job_scheduler.sv
// rtl/matmul_job_scheduler.sv - sequences one shared dot-product unit over an l x m by m x n product
// Issues one job per result element in row-major order and packs the returned floats into result.
module matmul_job_scheduler #(
   parameter int MAX_L = 4,
   parameter int MAX_M = 4,
   parameter int MAX_N = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [31:0]               l,
   input  logic [31:0]               m,
   input  logic [31:0]               n,
   output logic                      dp_start,
   output logic [31:0]               dp_row,
   output logic [31:0]               dp_col,
   output logic [31:0]               dp_len,
   input  logic                      dp_done,
   input  logic [31:0]               dp_result,
   output logic [32*MAX_L*MAX_N-1:0] result,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);
   localparam int SLOTS = MAX_L * MAX_N;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      state;
   logic [31:0] i_idx;
   logic [31:0] j_idx;
   logic [31:0] l_lat;
   logic [31:0] n_lat;
   logic [31:0] slot;
   logic        dims_ok;
   logic        last_col;
   logic        last_elem;

   always_comb begin
      dims_ok   = (l != 32'd0) && (l <= 32'(MAX_L)) &&
                  (m != 32'd0) && (m <= 32'(MAX_M)) &&
                  (n != 32'd0) && (n <= 32'(MAX_N));
      last_col  = (j_idx == n_lat - 32'd1);
      last_elem = last_col && (i_idx == l_lat - 32'd1);
      slot      = i_idx * n_lat + j_idx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         i_idx    <= '0;
         j_idx    <= '0;
         l_lat    <= '0;
         n_lat    <= '0;
         dp_start <= 1'b0;
         dp_row   <= '0;
         dp_col   <= '0;
         dp_len   <= '0;
         result   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         dp_start <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (dims_ok) begin
                     l_lat    <= l;
                     n_lat    <= n;
                     dp_len   <= m;
                     i_idx    <= '0;
                     j_idx    <= '0;
                     dp_row   <= '0;
                     dp_col   <= '0;
                     result   <= '0;
                     dp_start <= 1'b1;
                     busy     <= 1'b1;
                     state    <= ISSUE;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            // The unit needs at least one cycle, so a dp_done seen here is stale.
            ISSUE: state <= WAIT;
            WAIT: begin
               if (dp_done) begin
                  for (int s = 0; s < SLOTS; s++) begin
                     if (slot == 32'(s)) result[32*s +: 32] <= dp_result;
                  end
                  if (last_col) begin
                     j_idx <= '0;
                     i_idx <= i_idx + 32'd1;
                  end else begin
                     j_idx <= j_idx + 32'd1;
                  end
                  if (last_elem) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     dp_start <= 1'b1;
                     dp_row   <= last_col ? i_idx + 32'd1 : i_idx;
                     dp_col   <= last_col ? 32'd0 : j_idx + 32'd1;
                     state    <= ISSUE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matmul_job_scheduler.sv
// tb/tb_matmul_job_scheduler.sv - scenario bench for matmul_job_scheduler with a stub dot-product unit
// The stub returns per-element values chosen by the bench; expectations come from row-major arithmetic.
module tb_matmul_job_scheduler;
   localparam int ML = 4;
   localparam int MM = 4;
   localparam int MN = 4;
   localparam int W  = 32 * ML * MN;

   logic         clk = 1'b0;
   logic         reset, start, dp_done;
   logic [31:0]  l, m, n, dp_result;
   logic         dp_start, busy, done, err;
   logic [31:0]  dp_row, dp_col, dp_len;
   logic [W-1:0] result;

   int checks = 0;
   int fails  = 0;

   logic [31:0]  vals [16];
   logic [W-1:0] exp_res;

   int           st_cyc[$], st_row[$], st_col[$], st_len[$], done_cyc[$];
   int           err_cnt, busy_cnt, busy_first, busy_last;
   logic [W-1:0] res_c1, res_done, res_end;
   bit           timed_out;

   matmul_job_scheduler #(.MAX_L(ML), .MAX_M(MM), .MAX_N(MN)) dut (
      .clk(clk), .reset(reset), .start(start), .l(l), .m(m), .n(n),
      .dp_start(dp_start), .dp_row(dp_row), .dp_col(dp_col), .dp_len(dp_len),
      .dp_done(dp_done), .dp_result(dp_result), .result(result),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [W-1:0] model_result(input int tl, input int tn);
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < tl; i++)
         for (int j = 0; j < tn; j++)
            v[32*(i*tn+j) +: 32] = vals[i*tn+j];
      return v;
   endfunction

   task automatic fill_random_vals();
      for (int k = 0; k < 16; k++) vals[k] = $urandom | 32'h1;
   endtask

   // Start a product at the next negedge (cycle 0) and act as a unit of latency d.
   task automatic drive_run(input int tl, input int tm, input int tn, input int d,
                            input int poke_at, input int abort_at, input bit stray, input bit chain);
      int cnt;
      int pend;
      cnt = 0;
      pend = 0;
      st_cyc.delete(); st_row.delete(); st_col.delete(); st_len.delete(); done_cyc.delete();
      err_cnt = 0; busy_cnt = 0; busy_first = -1; busy_last = -1; timed_out = 1'b1;
      @(negedge clk);
      start = 1'b1; l = tl; m = tm; n = tn; dp_done = 1'b0;
      for (int cyc = 1; cyc < 300; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (cyc == abort_at) begin
            reset = 1'b1;
            dp_done = 1'b0;
            timed_out = 1'b0;
            break;
         end
         if (cyc == poke_at) begin
            start = 1'b1;
            l = 1;
         end
         if (dp_start) begin
            st_cyc.push_back(cyc); st_row.push_back(int'(dp_row));
            st_col.push_back(int'(dp_col)); st_len.push_back(int'(dp_len));
         end
         if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
         end
         if (err) err_cnt++;
         if (cyc == 1) res_c1 = result;
         res_end = result;
         dp_done = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               dp_done = 1'b1;
               dp_result = vals[pend];
            end
         end
         if (dp_start) begin
            cnt = d;
            pend = int'((dp_row * tn + dp_col) % 16);
         end
         if (done) begin
            done_cyc.push_back(cyc);
            res_done = result;
            if (stray) begin
               dp_done = 1'b1;
               dp_result = $urandom | 32'h1;
            end
         end
         if (done_cyc.size() > 0 && (chain || cyc >= done_cyc[0] + 2)) begin
            timed_out = 1'b0;
            break;
         end
      end
      if (!chain) dp_done = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; l = 2; m = 2; n = 2; dp_done = 1'b0; dp_result = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (dp_start !== 1'b0) begin fails++; $display("FAIL reset_dp_start: got %b expected 0", dp_start); end
      checks++; if ({dp_row, dp_col, dp_len} !== 96'd0) begin fails++; $display("FAIL reset_dp_bus: got %h expected 0", {dp_row, dp_col, dp_len}); end
      checks++; if ({done, err} !== 2'b00) begin fails++; $display("FAIL reset_done_err: got %b expected 00", {done, err}); end
      checks++; if (result !== '0) begin fails++; $display("FAIL reset_result: got %h expected 0", result); end
      exp_res = '0;
   endtask

   task automatic test_directed_2x3x2();
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            vals[i*2+j] = {16'(i), 16'(j)};
      drive_run(2, 3, 2, 3, 0, 0, 1'b0, 1'b0);
      checks++; if (timed_out) begin fails++; $display("FAIL dir_timeout: got no done expected done"); end
      checks++; if (st_cyc.size() != 4) begin fails++; $display("FAIL dir_job_count: got %0d expected 4", st_cyc.size()); end
      for (int k = 0; k < st_cyc.size() && k < 4; k++) begin
         checks++; if (st_cyc[k] != 1 + 4*k) begin fails++; $display("FAIL dir_start_cycle%0d: got %0d expected %0d", k, st_cyc[k], 1 + 4*k); end
         checks++; if (st_row[k] != k/2 || st_col[k] != k%2) begin fails++; $display("FAIL dir_rowcol%0d: got %0d,%0d expected %0d,%0d", k, st_row[k], st_col[k], k/2, k%2); end
         checks++; if (st_len[k] != 3) begin fails++; $display("FAIL dir_len%0d: got %0d expected 3", k, st_len[k]); end
      end
      checks++; if (done_cyc.size() != 1 || done_cyc[0] != 17) begin fails++; $display("FAIL dir_done_cycle: got %p expected 17", done_cyc); end
      checks++; if (busy_first != 1 || busy_last != 17 || busy_cnt != 17) begin fails++; $display("FAIL dir_busy: got %0d..%0d (%0d) expected 1..17 (17)", busy_first, busy_last, busy_cnt); end
      checks++; if (res_done[127:0] !== 128'h00010001_00010000_00000001_00000000) begin fails++; $display("FAIL dir_slots: got %h expected 00010001000100000000000100000000", res_done[127:0]); end
      checks++; if (res_done !== model_result(2, 2)) begin fails++; $display("FAIL dir_result: got %h expected %h", res_done, model_result(2, 2)); end
      exp_res = model_result(2, 2);
   endtask

   task automatic test_vector();
      vals[0] = $urandom | 32'h1;
      drive_run(1, 2, 1, 1, 0, 0, 1'b0, 1'b0);
      checks++; if (st_cyc.size() != 1) begin fails++; $display("FAIL vec_job_count: got %0d expected 1", st_cyc.size()); end
      checks++; if (st_cyc.size() > 0 && (st_row[0] != 0 || st_col[0] != 0 || st_len[0] != 2)) begin fails++; $display("FAIL vec_job: got %0d,%0d,%0d expected 0,0,2", st_row[0], st_col[0], st_len[0]); end
      checks++; if (res_c1 !== '0) begin fails++; $display("FAIL vec_clear_on_accept: got %h expected 0", res_c1); end
      checks++; if (done_cyc.size() != 1 || done_cyc[0] != 3) begin fails++; $display("FAIL vec_done_cycle: got %p expected 3", done_cyc); end
      checks++; if (res_done !== model_result(1, 1)) begin fails++; $display("FAIL vec_result: got %h expected %h", res_done, model_result(1, 1)); end
      exp_res = model_result(1, 1);
   endtask

   task automatic test_invalid();
      int dims [6][3];
      dims[0] = '{2, 0, 2};
      dims[1] = '{2, 2, 5};
      dims[2] = '{0, 1, 1};
      dims[3] = '{5, 1, 1};
      dims[4] = '{int'($urandom_range(1, 4)), int'($urandom_range(5, 200)), int'($urandom_range(1, 4))};
      dims[5] = '{int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 0};
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         start = 1'b1; l = dims[c][0]; m = dims[c][1]; n = dims[c][2];
         @(negedge clk);
         start = 1'b0;
         checks++; if (err !== 1'b1 || busy !== 1'b0 || dp_start !== 1'b0) begin fails++; $display("FAIL inv%0d_pulse: got err=%b busy=%b dp_start=%b expected 1,0,0", c, err, busy, dp_start); end
         @(negedge clk);
         checks++; if (err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL inv%0d_after: got err=%b busy=%b expected 0,0", c, err, busy); end
         checks++; if (result !== exp_res) begin fails++; $display("FAIL inv%0d_result: got %h expected %h", c, result, exp_res); end
      end
   endtask

   task automatic test_ignore_start();
      int d;
      d = int'($urandom_range(1, 3));
      fill_random_vals();
      drive_run(2, 2, 2, d, 3, 0, 1'b0, 1'b0);
      checks++; if (st_cyc.size() != 4) begin fails++; $display("FAIL ign_job_count: got %0d expected 4", st_cyc.size()); end
      checks++; if (done_cyc.size() != 1 || done_cyc[0] != 1 + 4*(d+1)) begin fails++; $display("FAIL ign_done: got %p expected %0d", done_cyc, 1 + 4*(d+1)); end
      checks++; if (err_cnt != 0) begin fails++; $display("FAIL ign_err: got %0d expected 0", err_cnt); end
      checks++; if (res_done !== model_result(2, 2)) begin fails++; $display("FAIL ign_result: got %h expected %h", res_done, model_result(2, 2)); end
      exp_res = model_result(2, 2);
   endtask

   task automatic test_reset_mid();
      fill_random_vals();
      drive_run(2, 2, 2, 3, 0, 10, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      checks++; if (st_cyc.size() != 3) begin fails++; $display("FAIL rst_jobs_before: got %0d expected 3", st_cyc.size()); end
      checks++; if ({dp_start, busy, done, err} !== 4'b0000) begin fails++; $display("FAIL rst_flags: got %b expected 0000", {dp_start, busy, done, err}); end
      checks++; if ({dp_row, dp_col, dp_len} !== 96'd0) begin fails++; $display("FAIL rst_dp_bus: got %h expected 0", {dp_row, dp_col, dp_len}); end
      checks++; if (result !== '0) begin fails++; $display("FAIL rst_result: got %h expected 0", result); end
      @(negedge clk);
      dp_done = 1'b1; dp_result = $urandom | 32'h1;
      @(negedge clk);
      dp_done = 1'b0;
      checks++; if (result !== '0 || busy !== 1'b0 || dp_start !== 1'b0) begin fails++; $display("FAIL rst_late_done: got result=%h busy=%b expected 0", result, busy); end
      exp_res = '0;
      fill_random_vals();
      drive_run(1, 1, 2, 2, 0, 0, 1'b0, 1'b0);
      checks++; if (done_cyc.size() != 1 || done_cyc[0] != 7) begin fails++; $display("FAIL rst_rerun_done: got %p expected 7", done_cyc); end
      checks++; if (res_done !== model_result(1, 2)) begin fails++; $display("FAIL rst_rerun_result: got %h expected %h", res_done, model_result(1, 2)); end
      exp_res = model_result(1, 2);
   endtask

   task automatic test_back_to_back();
      fill_random_vals();
      drive_run(2, 2, 2, 1, 0, 0, 1'b1, 1'b1);
      checks++; if (done_cyc.size() != 1 || done_cyc[0] != 9) begin fails++; $display("FAIL b2b_first_done: got %p expected 9", done_cyc); end
      checks++; if (res_done !== model_result(2, 2)) begin fails++; $display("FAIL b2b_first_result: got %h expected %h", res_done, model_result(2, 2)); end
      vals[0] = $urandom | 32'h1;
      drive_run(1, 1, 1, 2, 0, 0, 1'b0, 1'b0);
      checks++; if (st_cyc.size() != 1 || st_cyc[0] != 1) begin fails++; $display("FAIL b2b_accept: got %p expected [1]", st_cyc); end
      checks++; if (res_c1 !== '0) begin fails++; $display("FAIL b2b_clear: got %h expected 0", res_c1); end
      checks++; if (done_cyc.size() != 1 || done_cyc[0] != 4) begin fails++; $display("FAIL b2b_second_done: got %p expected 4", done_cyc); end
      checks++; if (res_done !== model_result(1, 1)) begin fails++; $display("FAIL b2b_second_result: got %h expected %h", res_done, model_result(1, 1)); end
      exp_res = model_result(1, 1);
   endtask

   task automatic test_random();
      int tl, tm, tn, d, jobs;
      bit stray;
      for (int r = 0; r < 8; r++) begin
         tl = int'($urandom_range(1, ML)); tm = int'($urandom_range(1, MM));
         tn = int'($urandom_range(1, MN)); d = int'($urandom_range(1, 4));
         stray = 1'($urandom_range(0, 1));
         jobs = tl * tn;
         fill_random_vals();
         drive_run(tl, tm, tn, d, 0, 0, stray, 1'b0);
         checks++; if (timed_out) begin fails++; $display("FAIL rnd%0d_timeout: got no done expected done", r); end
         checks++; if (st_cyc.size() != jobs) begin fails++; $display("FAIL rnd%0d_job_count: got %0d expected %0d", r, st_cyc.size(), jobs); end
         for (int k = 0; k < st_cyc.size() && k < jobs; k++) begin
            checks++;
            if (st_cyc[k] != 1 + k*(d+1) || st_row[k] != k/tn || st_col[k] != k%tn || st_len[k] != tm) begin
               fails++;
               $display("FAIL rnd%0d_job%0d: got cyc=%0d row=%0d col=%0d len=%0d expected %0d,%0d,%0d,%0d",
                        r, k, st_cyc[k], st_row[k], st_col[k], st_len[k], 1 + k*(d+1), k/tn, k%tn, tm);
            end
         end
         checks++; if (done_cyc.size() != 1 || done_cyc[0] != 1 + jobs*(d+1)) begin fails++; $display("FAIL rnd%0d_done: got %p expected %0d", r, done_cyc, 1 + jobs*(d+1)); end
         checks++; if (busy_cnt != 1 + jobs*(d+1) || err_cnt != 0) begin fails++; $display("FAIL rnd%0d_busy_err: got busy=%0d err=%0d expected %0d,0", r, busy_cnt, err_cnt, 1 + jobs*(d+1)); end
         checks++; if (res_done !== model_result(tl, tn)) begin fails++; $display("FAIL rnd%0d_result: got %h expected %h", r, res_done, model_result(tl, tn)); end
         checks++; if (res_end !== model_result(tl, tn)) begin fails++; $display("FAIL rnd%0d_hold: got %h expected %h", r, res_end, model_result(tl, tn)); end
         exp_res = model_result(tl, tn);
      end
   endtask

   initial begin
      test_reset();
      test_directed_2x3x2();
      test_vector();
      test_invalid();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/matmul_job_scheduler.md
Name: matmul_job_scheduler

Overview:
- Sequences one shared float dot-product unit to compute an l x m by m x n matrix product, one output element at a time.
- Runtime dimensions l, m, n are latched at start. Operand buffers (A row-major, B_T row-major) stay outside this block.
- For each element (i,j) the block issues one job to the unit, collects the 32-bit float result, and packs it into a row-major result bus in the same layout the matrix-multiplication modules use.
- Completion is signalled with a one-cycle done pulse.

Parameters:
- MAX_L, 4, maximum supported rows of A / rows of result.
- MAX_M, 4, maximum supported inner dimension (passed through as job length).
- MAX_N, 4, maximum supported columns of result.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new product; sampled only in IDLE.
- l  in  32  rows of A, unsigned, valid 1..MAX_L.
- m  in  32  inner dimension, unsigned, valid 1..MAX_M.
- n  in  32  columns of B, unsigned, valid 1..MAX_N.
- dp_start  out  1  one-cycle job issue pulse to the dot-product unit.
- dp_row  out  32  row index i of A for the current job.
- dp_col  out  32  row index j of B_T for the current job.
- dp_len  out  32  latched m (dot-product length).
- dp_done  in  1  unit result valid (single-cycle pulse).
- dp_result  in  32  IEEE-754 single float for the current job.
- result  out  32*MAX_L*MAX_N  element (i,j) at bits [32*(i*n_latched+j) +: 32]; unused upper slots hold 0.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result complete and stable.
- err  out  1  one-cycle pulse; start rejected for invalid dims.

Behaviour:
- Reset values: dp_start=0, dp_row=0, dp_col=0, dp_len=0, result=0, busy=0, done=0, err=0, state=IDLE, i=j=0, latched dims=0.
- States are IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On start with all dims in range: latch l,m,n; set i=j=0; clear result to 0; go to ISSUE.
  - On start with any dim 0 or above its MAX: err=1 for one cycle; stay in IDLE; result untouched.
- ISSUE:
  - dp_start=1 for exactly one cycle, with dp_row=i, dp_col=j, dp_len=m latched.
  - Go to WAIT.
  - A dp_done arriving in the ISSUE cycle is ignored, since the unit latency is at least 1.
- WAIT:
  - Hold dp_row/dp_col/dp_len; dp_start=0.
  - On dp_done: write dp_result to slot i*n+j.
  - If j==n-1, set j=0 and i=i+1; otherwise set j=j+1.
  - If (i,j) was (l-1,n-1), go to DONE; otherwise go to ISSUE.
- DONE: done=1 for one cycle; go to IDLE. result holds until the next accepted start or reset.
- Latency, for unit latency D>=1 (dp_done D cycles after the dp_start cycle):
  - start sampled at cycle 0.
  - First dp_start at cycle 1.
  - Each element takes D+1 cycles.
  - done at cycle 1 + l*n*(D+1).
- Jobs are issued strictly in row-major order. At most one job is outstanding.
- start while busy is ignored: no err, and the latched dims are unchanged.
- Changes on l/m/n while busy have no effect.
- dp_done while in IDLE or DONE is ignored; result is unchanged.
- Reset mid-operation: return to reset values on the next edge; no done pulse. The unit may still pulse dp_done afterwards, and that pulse is ignored.
- start in the same cycle as reset: reset wins.
- Index and slot arithmetic is unsigned 32-bit. Slot bound i*n+j < MAX_L*MAX_N is guaranteed by dimension checking.

Test Plan:
- l=2,m=3,n=2; stub unit D=3 returns {16'h(i), 16'h(j)} -> dp_len=3; dp_start at cycles 1,5,9,13; done at cycle 17; result slots 0..3 = 0000_0000, 0000_0001, 0001_0000, 0001_0001; busy high cycles 1..17.
- l=1,m=2,n=1 (vector case), D=1 -> exactly one dp_start (row 0, col 0); done at cycle 3; slot 0 = dp_result; slots 1..15 = 0.
- m=0 (and separately n=5 with MAX_N=4) -> err pulse at cycle 1; busy stays 0; no dp_start; previous result retained.
- start re-asserted and l changed to 1 during the 2x2x2 run -> ignored; still 4 jobs; done once; no err.
- Reset asserted while in WAIT of the 3rd job, with a late dp_done 2 cycles later -> all outputs 0 after the reset edge; late dp_done leaves result 0; a subsequent start runs normally.
- Back-to-back: 2x2x2 run, then 1x1x1 with start the cycle after done -> second run accepted; result cleared at accept; only slot 0 nonzero at second done.
